// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode constants, FSM
// state encoding and the opcode field locator used on raw IB words.
`ifndef INST_SEQUENCER_PKG_SV
`define INST_SEQUENCER_PKG_SV

// Opcode occupies the top OW bits of an IW-bit instruction word.
`define SEQ_OPC_FIELD(IW, OW) [(IW)-1 -: (OW)]

package inst_sequencer_pkg;

  localparam logic [3:0] OPC_HALT    = 4'h0;
  localparam logic [3:0] OPC_NOP     = 4'h1;
  localparam logic [3:0] OPC_ILLEGAL = 4'hF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REWIND,
    ST_DISCARD,
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_ISSUE,
    ST_EXEC,
    ST_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    OPK_HALT,
    OPK_NOP,
    OPK_EXEC,
    OPK_ILLEGAL
  } opc_kind_e;

endpackage

`endif

// File: rtl/inst_sequencer_watchdog.sv
// Fetch watchdog: a down-counter armed on each IB strobe; expire_o marks the
// last cycle in which a read-valid is still accepted.
module seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic internal_clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Cycle F+k after the strobe holds TIMEOUT-k, so the value 1 lands on cycle F+TIMEOUT-1.
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge internal_clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CW'(1));

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: rewinds the IB, fetches and decodes one word at a
// time, issues EXEC ops over valid/ready and retires them on op_done.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int INST_BITS = 128,
  parameter int OPC_BITS  = 4,
  parameter int CNT_BITS  = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                          internal_clk,
  input  logic                          reset_n,
  input  logic                          start,
  output logic                          ib_flag,
  output logic                          ib_jmp,
  input  logic                          ib_complete,
  input  logic [INST_BITS-1:0]          instruction,
  input  logic                          init_inst_pulse,
  output logic                          op_valid,
  output logic [OPC_BITS-1:0]           op_code,
  output logic [INST_BITS-OPC_BITS-1:0] op_operand,
  input  logic                          op_ready,
  input  logic                          op_done,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [CNT_BITS-1:0]           retired
);

  seq_state_e                    state_q, state_d;
  logic [OPC_BITS-1:0]           opc_q, opc_d;
  logic [INST_BITS-OPC_BITS-1:0] operand_q, operand_d;
  logic                          last_q, last_d;
  logic                          err_q, err_d;
  logic [CNT_BITS-1:0]           retired_q, retired_d;

  logic      wd_load;
  logic      wd_clear;
  logic      wd_expire;
  opc_kind_e opc_kind;

  // The watchdog runs only while a strobe is outstanding.
  assign wd_load  = (state_q == ST_REWIND) || (state_q == ST_FETCH);
  assign wd_clear = (state_q != ST_DISCARD) && (state_q != ST_WAIT);

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .internal_clk (internal_clk),
    .reset_n      (reset_n),
    .load_i       (wd_load),
    .clear_i      (wd_clear),
    .expire_o     (wd_expire)
  );

  always_comb begin
    opc_kind = OPK_EXEC;
    if (opc_q == OPC_BITS'(OPC_HALT)) begin
      opc_kind = OPK_HALT;
    end else if (opc_q == OPC_BITS'(OPC_NOP)) begin
      opc_kind = OPK_NOP;
    end else if (opc_q == OPC_BITS'(OPC_ILLEGAL)) begin
      opc_kind = OPK_ILLEGAL;
    end
  end

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    operand_d = operand_q;
    last_d    = last_q;
    err_d     = err_q;
    retired_d = retired_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_REWIND;
          err_d     = 1'b0;
          retired_d = '0;
        end
      end

      ST_REWIND: state_d = ST_DISCARD;

      // A response that arrives on the watchdog's final cycle still wins.
      ST_DISCARD: begin
        if (init_inst_pulse) begin
          state_d = ST_FETCH;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_FETCH: state_d = ST_WAIT;

      ST_WAIT: begin
        if (init_inst_pulse) begin
          opc_d     = instruction `SEQ_OPC_FIELD(INST_BITS, OPC_BITS);
          operand_d = instruction[INST_BITS-OPC_BITS-1:0];
          last_d    = ib_complete;
          state_d   = ST_DECODE;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DECODE: begin
        case (opc_kind)
          OPK_HALT: state_d = ST_DONE;
          OPK_NOP: begin
            retired_d = retired_q + CNT_BITS'(1);
            state_d   = last_q ? ST_DONE : ST_FETCH;
          end
          OPK_ILLEGAL: begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
          default: state_d = ST_ISSUE;
        endcase
      end

      ST_ISSUE: begin
        if (op_ready) begin
          state_d = ST_EXEC;
        end
      end

      // op_done is only honoured here, never in the transfer cycle itself.
      ST_EXEC: begin
        if (op_done) begin
          retired_d = retired_q + CNT_BITS'(1);
          state_d   = last_q ? ST_DONE : ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge internal_clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      opc_q     <= '0;
      operand_q <= '0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      operand_q <= operand_d;
      last_q    <= last_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign ib_flag    = (state_q == ST_REWIND) || (state_q == ST_FETCH);
  assign ib_jmp     = (state_q == ST_REWIND);
  assign op_valid   = (state_q == ST_ISSUE);
  assign op_code    = opc_q;
  assign op_operand = operand_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer with a behavioural IB and execution unit.
module tb_inst_sequencer;

  logic         internal_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         ib_flag, ib_jmp;
  logic         ib_complete = 1'b0;
  logic [127:0] instruction = '0;
  logic         init_inst_pulse = 1'b0;
  logic         op_valid;
  logic [3:0]   op_code;
  logic [123:0] op_operand;
  logic         op_ready = 1'b0;
  logic         op_done = 1'b0;
  logic         busy, done, err;
  logic [15:0]  retired;

  int passed = 0;
  int total  = 0;

  inst_sequencer dut (
    .internal_clk    (internal_clk),
    .reset_n         (reset_n),
    .start           (start),
    .ib_flag         (ib_flag),
    .ib_jmp          (ib_jmp),
    .ib_complete     (ib_complete),
    .instruction     (instruction),
    .init_inst_pulse (init_inst_pulse),
    .op_valid        (op_valid),
    .op_code         (op_code),
    .op_operand      (op_operand),
    .op_ready        (op_ready),
    .op_done         (op_done),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .retired         (retired)
  );

  always #5 internal_clk = ~internal_clk;

  int cyc = 0;
  always @(posedge internal_clk) cyc <= cyc + 1;

  // Program and model configuration, written only by the stimulus tasks.
  logic [127:0] mem [8];
  int n_words = 0;
  int lat = 1;
  int ready_delay = 0;
  int done_delay = 1;
  bit extra_done = 1'b0;
  bit fetch_resp = 1'b1;

  // Statistics, written only by the models/monitors below.
  int n_flag = 0, n_jmp = 0, flag_b2b = 0;
  int n_xfer = 0, valid_cycles = 0, stable_viol = 0;
  int t_fetch = 0, t_err = -1;
  logic [3:0]   last_code = '0;
  logic [123:0] last_opnd = '0;

  function automatic logic [127:0] mk(input logic [3:0] opc, input logic [31:0] val);
    return {opc, 124'(val)};
  endfunction

  // IB model: responds lat cycles after each strobe.
  int rcnt = 0, ptr = 0;
  bit prev_flag = 1'b0;
  logic [127:0] pend_word = '0;
  bit pend_last = 1'b0;
  always @(negedge internal_clk) begin
    init_inst_pulse = 1'b0;
    instruction = '0;
    ib_complete = 1'b0;
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        init_inst_pulse = 1'b1;
        instruction = pend_word;
        ib_complete = pend_last;
      end
    end
    if (ib_flag) begin
      n_flag++;
      if (prev_flag) flag_b2b++;
      if (ib_jmp) begin
        n_jmp++;
        ptr = 0;
        pend_word = mem[0];
        pend_last = 1'b0;
        rcnt = lat;
      end else begin
        t_fetch = cyc;
        pend_word = (ptr < 8) ? mem[ptr] : '0;
        pend_last = (ptr == n_words - 1);
        ptr++;
        if (fetch_resp) rcnt = lat;
      end
    end
    prev_flag = ib_flag;
  end

  // Execution unit model: ready after ready_delay valid cycles, done done_delay cycles after transfer.
  int vcnt = 0, dcnt = 0;
  logic [3:0]   hold_code = '0;
  logic [123:0] hold_opnd = '0;
  always @(negedge internal_clk) begin
    op_done = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) op_done = 1'b1;
    end
    op_ready = 1'b0;
    if (op_valid) begin
      if (vcnt == 0) begin
        hold_code = op_code;
        hold_opnd = op_operand;
      end else if (op_code !== hold_code || op_operand !== hold_opnd) begin
        stable_viol++;
      end
      op_ready = (vcnt >= ready_delay);
      if (extra_done) op_done = 1'b1;
      vcnt++;
      valid_cycles++;
      if (op_ready) begin
        n_xfer++;
        last_code = op_code;
        last_opnd = op_operand;
        vcnt = 0;
        dcnt = done_delay;
      end
    end else begin
      vcnt = 0;
    end
  end

  bit err_prev = 1'b0;
  always @(negedge internal_clk) begin
    if (err && !err_prev) t_err = cyc;
    err_prev = err;
  end

  task automatic apply_reset;
    reset_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge internal_clk);
    reset_n = 1'b1;
    @(negedge internal_clk);
  endtask

  task automatic start_pulse;
    @(negedge internal_clk);
    start = 1'b1;
    @(negedge internal_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge internal_clk);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge internal_clk);
    total++; if (ib_flag !== 1'b0) $display("FAIL reset_ib_flag: got %b want 0", ib_flag); else passed++;
    total++; if (ib_jmp !== 1'b0) $display("FAIL reset_ib_jmp: got %b want 0", ib_jmp); else passed++;
    total++; if (op_valid !== 1'b0) $display("FAIL reset_op_valid: got %b want 0", op_valid); else passed++;
    total++; if (op_code !== 4'h0) $display("FAIL reset_op_code: got %h want 0", op_code); else passed++;
    total++; if (op_operand !== '0) $display("FAIL reset_op_operand: got %h want 0", op_operand); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    total++; if (retired !== 16'd0) $display("FAIL reset_retired: got %0d want 0", retired); else passed++;
    reset_n = 1'b1;
    @(negedge internal_clk);
  endtask

  task automatic test_basic;
    int f0, j0, x0, b0;
    bit ok;
    mem[0] = mk(4'h1, 32'h0);
    mem[1] = mk(4'h2, 32'hABC);
    mem[2] = mk(4'h0, 32'h0);
    n_words = 3;
    f0 = n_flag; j0 = n_jmp; x0 = n_xfer; b0 = flag_b2b;
    start_pulse();
    wait_done(200, ok);
    repeat (3) @(negedge internal_clk);
    total++; if (!ok) $display("FAIL basic_timeout: done never rose within 200 cycles"); else passed++;
    total++; if (n_flag - f0 != 4) $display("FAIL basic_strobes: got %0d want 4", n_flag - f0); else passed++;
    total++; if (n_jmp - j0 != 1) $display("FAIL basic_rewinds: got %0d want 1", n_jmp - j0); else passed++;
    total++; if (n_xfer - x0 != 1) $display("FAIL basic_issues: got %0d want 1", n_xfer - x0); else passed++;
    total++; if (last_code !== 4'h2) $display("FAIL basic_op_code: got %h want 2", last_code); else passed++;
    total++; if (last_opnd !== 124'hABC) $display("FAIL basic_operand: got %h want abc", last_opnd); else passed++;
    total++; if (retired !== 16'd2) $display("FAIL basic_retired: got %0d want 2", retired); else passed++;
    total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL basic_status: got done=%b busy=%b want 1/0", done, busy); else passed++;
    total++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else passed++;
    total++; if (flag_b2b != b0) $display("FAIL basic_strobe_gap: got %0d back-to-back strobes want 0", flag_b2b - b0); else passed++;
  endtask

  task automatic test_issue_stall;
    int x0, v0, s0;
    bit ok;
    apply_reset();
    mem[0] = mk(4'h5, 32'h1234);
    mem[1] = mk(4'h0, 32'h0);
    n_words = 2;
    ready_delay = 7; extra_done = 1'b1; done_delay = 2;
    x0 = n_xfer; v0 = valid_cycles; s0 = stable_viol;
    start_pulse();
    wait_done(200, ok);
    repeat (3) @(negedge internal_clk);
    ready_delay = 0; extra_done = 1'b0; done_delay = 1;
    total++; if (!ok) $display("FAIL stall_timeout: done never rose within 200 cycles"); else passed++;
    total++; if (n_xfer - x0 != 1) $display("FAIL stall_transfers: got %0d want 1", n_xfer - x0); else passed++;
    total++; if (valid_cycles - v0 != 8) $display("FAIL stall_valid_cycles: got %0d want 8", valid_cycles - v0); else passed++;
    total++; if (stable_viol != s0) $display("FAIL stall_stability: got %0d changes want 0", stable_viol - s0); else passed++;
    total++; if (last_code !== 4'h5 || last_opnd !== 124'h1234) $display("FAIL stall_payload: got %h/%h want 5/1234", last_code, last_opnd); else passed++;
    total++; if (retired !== 16'd1) $display("FAIL stall_retired: got %0d want 1", retired); else passed++;
  endtask

  task automatic test_last_word;
    int f0, x0;
    bit ok;
    apply_reset();
    mem[0] = mk(4'h1, 32'h0);
    mem[1] = mk(4'h3, 32'h77);
    n_words = 2;
    f0 = n_flag; x0 = n_xfer;
    start_pulse();
    wait_done(200, ok);
    repeat (6) @(negedge internal_clk);
    total++; if (!ok) $display("FAIL last_timeout: done never rose within 200 cycles"); else passed++;
    total++; if (n_flag - f0 != 3) $display("FAIL last_strobes: got %0d want 3", n_flag - f0); else passed++;
    total++; if (n_xfer - x0 != 1 || last_code !== 4'h3) $display("FAIL last_issue: got %0d issues code %h want 1 code 3", n_xfer - x0, last_code); else passed++;
    total++; if (retired !== 16'd2) $display("FAIL last_retired: got %0d want 2", retired); else passed++;
    total++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL last_status: got done=%b err=%b want 1/0", done, err); else passed++;
  endtask

  task automatic test_latency;
    bit ok;
    apply_reset();
    mem[0] = mk(4'h1, 32'h0);
    mem[1] = mk(4'h0, 32'h0);
    n_words = 2;
    lat = 63;
    start_pulse();
    wait_done(600, ok);
    repeat (2) @(negedge internal_clk);
    lat = 1;
    total++; if (!ok) $display("FAIL latency_timeout: done never rose within 600 cycles"); else passed++;
    total++; if (err !== 1'b0) $display("FAIL latency_err: got %b want 0", err); else passed++;
    total++; if (retired !== 16'd1) $display("FAIL latency_retired: got %0d want 1", retired); else passed++;
  endtask

  task automatic test_timeout;
    bit ok;
    apply_reset();
    mem[0] = mk(4'h1, 32'h0);
    n_words = 1;
    fetch_resp = 1'b0;
    start_pulse();
    wait_done(300, ok);
    repeat (2) @(negedge internal_clk);
    fetch_resp = 1'b1;
    total++; if (!ok) $display("FAIL timeout_bound: done never rose within 300 cycles"); else passed++;
    total++; if (err !== 1'b1) $display("FAIL timeout_err: got %b want 1", err); else passed++;
    total++; if (t_err - t_fetch != 64) $display("FAIL timeout_cycle: got %0d want 64", t_err - t_fetch); else passed++;
    total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL timeout_status: got done=%b busy=%b want 1/0", done, busy); else passed++;
    total++; if (retired !== 16'd0) $display("FAIL timeout_retired: got %0d want 0", retired); else passed++;
  endtask

  task automatic test_illegal_restart;
    int f0, x0;
    bit ok;
    apply_reset();
    mem[0] = mk(4'h1, 32'h0);
    mem[1] = mk(4'hF, 32'h99);
    mem[2] = mk(4'h2, 32'h5);
    n_words = 3;
    f0 = n_flag; x0 = n_xfer;
    start_pulse();
    wait_done(200, ok);
    repeat (2) @(negedge internal_clk);
    total++; if (!ok || err !== 1'b1) $display("FAIL illegal_err: got done_seen=%b err=%b want 1/1", ok, err); else passed++;
    total++; if (n_xfer != x0) $display("FAIL illegal_no_issue: got %0d issues want 0", n_xfer - x0); else passed++;
    total++; if (n_flag - f0 != 3) $display("FAIL illegal_strobes: got %0d want 3", n_flag - f0); else passed++;
    total++; if (retired !== 16'd1) $display("FAIL illegal_retired: got %0d want 1", retired); else passed++;
    mem[0] = mk(4'h0, 32'h0);
    n_words = 1;
    start_pulse();
    total++; if (err !== 1'b0 || retired !== 16'd0) $display("FAIL restart_clear: got err=%b retired=%0d want 0/0", err, retired); else passed++;
    total++; if (busy !== 1'b1 || ib_jmp !== 1'b1) $display("FAIL restart_rewind: got busy=%b ib_jmp=%b want 1/1", busy, ib_jmp); else passed++;
    wait_done(200, ok);
    total++; if (!ok || err !== 1'b0 || retired !== 16'd0) $display("FAIL restart_halt: got done_seen=%b err=%b retired=%0d want 1/0/0", ok, err, retired); else passed++;
  endtask

  task automatic test_reset_mid_exec;
    int x0;
    bit seen;
    apply_reset();
    mem[0] = mk(4'h4, 32'h4242);
    mem[1] = mk(4'h0, 32'h0);
    n_words = 2;
    done_delay = 10;
    x0 = n_xfer;
    seen = 1'b0;
    start_pulse();
    for (int i = 0; i < 100; i++) begin
      @(negedge internal_clk);
      if (n_xfer != x0) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge internal_clk);
    total++; if (!seen || op_code !== 4'h4) $display("FAIL midrst_reach_exec: got seen=%b op_code=%h want 1/4", seen, op_code); else passed++;
    reset_n = 1'b0;
    @(posedge internal_clk);
    #1;
    total++; if (ib_flag !== 1'b0 || ib_jmp !== 1'b0 || op_valid !== 1'b0) $display("FAIL midrst_strobes: got %b%b%b want 000", ib_flag, ib_jmp, op_valid); else passed++;
    total++; if (op_code !== 4'h0 || op_operand !== '0) $display("FAIL midrst_payload: got %h/%h want 0/0", op_code, op_operand); else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) $display("FAIL midrst_status: got busy=%b done=%b err=%b want 0/0/0", busy, done, err); else passed++;
    total++; if (retired !== 16'd0) $display("FAIL midrst_retired: got %0d want 0", retired); else passed++;
    @(negedge internal_clk);
    reset_n = 1'b1;
    repeat (14) @(negedge internal_clk);
    done_delay = 1;
    total++; if (retired !== 16'd0) $display("FAIL midrst_late_done: got retired=%0d want 0", retired); else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_idle: got busy=%b done=%b want 0/0", busy, done); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_issue_stall();
    test_last_word();
    test_latency();
    test_timeout();
    test_illegal_restart();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
